plic_core: RTL

Parametrised platform-level interrupt core for one hart context:
- per-source gateways with pending and in-flight tracking;
- a priority/threshold arbiter;
- a claim/complete handshake to the hart.

It succeeds the fixed 5-source notifier. It adds arbitrary source count, completion tracking, and optional edge-triggered sources. It sits between the external interrupt lines and the core's machine external interrupt (MEIP) input and claim/complete CSR path.

---
 rtl/plic_core.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/plic_core.sv
// plic_core: platform-level interrupt core for a single hart context.
// Per-source gateways track pending/in-flight state. A priority/threshold
// arbiter drives eip. A two-state FSM handles the claim/complete handshake.
// Optional feature: define PLIC_EDGE_TRIG_EN to add per-source edge-triggered
// gateways (edge_mode input plus a previous-sample register per source).

module plic_gateway (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_irq,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic i_edge_mode,
`endif
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending
);
  logic r_pending;
  logic r_inflight;
  logic w_set;

`ifdef PLIC_EDGE_TRIG_EN
  logic r_prev;

  // previous sample of the raw line for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_irq;

  // edges arriving while pending or in flight are dropped, not queued
  assign w_set = i_edge_mode ? (i_irq & ~r_prev & ~r_pending & ~r_inflight)
                             : (i_irq & ~r_inflight);
`else
  assign w_set = i_irq & ~r_inflight;
`endif

  // pending: claim wins over a fresh set in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)      r_pending <= 1'b0;
    else if (i_claim)  r_pending <= 1'b0;
    else if (w_set)    r_pending <= 1'b1;

  // in-flight: claim wins over a same-cycle complete of this source
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)         r_inflight <= 1'b0;
    else if (i_claim)     r_inflight <= 1'b1;
    else if (i_complete)  r_inflight <= 1'b0;

  assign o_pending = r_pending;
endmodule

module plic_core #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NSRC-1:0]        i_irq_src,
  input  logic [NSRC-1:0]        i_irq_en,
  input  logic [NSRC*PRIO_W-1:0] i_prio,
  input  logic [PRIO_W-1:0]      i_threshold,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic [NSRC-1:0]        i_edge_mode,
`endif
  output logic                   o_eip,
  input  logic                   i_claim_req,
  output logic                   o_claim_valid,
  output logic [ID_W-1:0]        o_claim_id,
  input  logic                   i_complete_req,
  input  logic [ID_W-1:0]        i_complete_id,
  output logic [NSRC-1:0]        o_pending
);
  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [ID_W-1:0]   id;
  } arb_t;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  arb_t            r_max, w_best;
  logic [ID_W-1:0] r_claim_id;
  logic [NSRC-1:0] w_pending;
  logic            w_above;
  logic            w_grant;

  assign w_above = (r_max.prio > i_threshold);
  // a claim only takes effect when something is actually interrupting
  assign w_grant = (r_state == S_IDLE) & i_claim_req & w_above;

  for (genvar g = 0; g < NSRC; g++) begin : g_gw
    localparam logic [ID_W-1:0] GID = ID_W'(g + 1);
    plic_gateway u_gw (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_irq      (i_irq_src[g]),
`ifdef PLIC_EDGE_TRIG_EN
      .i_edge_mode(i_edge_mode[g]),
`endif
      .i_claim    (w_grant && (r_max.id == GID)),
      .i_complete (i_complete_req && (i_complete_id == GID)),
      .o_pending  (w_pending[g])
    );
  end

  // highest priority wins; strict compare keeps the lowest ID on ties
  always_comb begin
    w_best = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (w_pending[k] && i_irq_en[k] && (i_prio[k*PRIO_W +: PRIO_W] > w_best.prio)) begin
        w_best.prio = i_prio[k*PRIO_W +: PRIO_W];
        w_best.id   = ID_W'(k + 1);
      end
    end
  end

  // registered arbitration result
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_max <= '0;
    else          r_max <= w_best;

  // handshake state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;

  // IDLE accepts a claim strobe; RESP lasts exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_claim_req) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // claim response ID, zero when nothing was claimable
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_claim_id <= '0;
    else          r_claim_id <= w_grant ? r_max.id : '0;

  // eip is hidden during RESP while r_max still reflects the claimed source
  assign o_eip         = (r_state == S_IDLE) & w_above;
  assign o_claim_valid = (r_state == S_RESP);
  assign o_claim_id    = r_claim_id;
  assign o_pending     = w_pending;
endmodule
